// File: rtl/pyramid_merge_arbiter.sv
// Two-producer to one-consumer token merger with round-robin burst grants.
// A grant ends after BURST_LEN tokens or after TIMEOUT idle cycles of its owner.
module pyramid_merge_arbiter #(
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        In0_SEND,
  input  logic [15:0] In0_DATA,
  input  logic [15:0] In0_COUNT,
  output logic        In0_ACK,
  input  logic        In1_SEND,
  input  logic [15:0] In1_DATA,
  input  logic [15:0] In1_COUNT,
  output logic        In1_ACK,
  input  logic        Out1_RDY,
  input  logic        Out1_ACK,
  output logic        Out1_SEND,
  output logic [15:0] Out1_DATA,
  output logic [15:0] Out1_COUNT,
  output logic [1:0]  GRANT
);

  localparam logic [15:0] BURST_LAST = 16'(BURST_LEN - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(TIMEOUT - 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);

  // State encodings double as the one-hot GRANT value.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t      state;
  logic        last;
  logic [15:0] bcnt;
  logic [15:0] icnt;

  logic        owner_send;
  logic [15:0] owner_data;
  logic        xfer;
  logic        unused;

  assign unused = ^{In0_COUNT, In1_COUNT, Out1_ACK};

  always_comb begin
    owner_send = 1'b0;
    owner_data = '0;
    case (state)
      OWN0: begin
        owner_send = In0_SEND;
        owner_data = In0_DATA;
      end
      OWN1: begin
        owner_send = In1_SEND;
        owner_data = In1_DATA;
      end
      default: ;
    endcase
  end

  assign xfer       = owner_send & Out1_RDY;
  assign In0_ACK    = xfer & (state == OWN0);
  assign In1_ACK    = xfer & (state == OWN1);
  assign Out1_SEND  = xfer;
  assign Out1_DATA  = xfer ? owner_data : '0;
  assign Out1_COUNT = xfer ? 16'h0001 : '0;
  assign GRANT      = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      last  <= 1'b1;
      bcnt  <= '0;
      icnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Counters are held clear while idle so every OWN state starts fresh.
          bcnt <= '0;
          icnt <= '0;
          if (In0_SEND && In1_SEND) state <= last ? OWN0 : OWN1;
          else if (In0_SEND)        state <= OWN0;
          else if (In1_SEND)        state <= OWN1;
        end
        OWN0, OWN1: begin
          if (owner_send) begin
            icnt <= '0;
            if (Out1_RDY) begin
              if (bcnt == BURST_LAST) begin
                last  <= (state == OWN1);
                state <= IDLE;
              end else begin
                bcnt <= bcnt + 16'd1;
              end
            end
          end else if (TIMEOUT_EN && icnt == IDLE_LAST) begin
            last  <= (state == OWN1);
            state <= IDLE;
          end else if (icnt != '1) begin
            icnt <= icnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pyramid_merge_arbiter.sv
// Bench for pyramid_merge_arbiter: two instances (burst 4/timeout 16 and burst 1/no timeout)
// driven in lockstep, checked against a cycle model and hand-derived vectors.
module tb_pyramid_merge_arbiter;

  localparam int BL_A = 4;
  localparam int TO_A = 16;
  localparam int BL_B = 1;
  localparam int TO_B = 0;

  typedef struct packed {
    logic [1:0]  grant;
    logic        ack0;
    logic        ack1;
    logic        send;
    logic [15:0] data;
    logic [15:0] count;
  } out_t;

  typedef struct {
    int st;
    bit last;
    int bcnt;
    int icnt;
  } mst_t;

  typedef struct {
    out_t a;
    out_t b;
    bit   has_tab;
    out_t tab;
  } exp_t;

  typedef struct {
    logic        s0;
    logic        s1;
    logic        rdy;
    logic [15:0] d0;
    logic [15:0] d1;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s0 = 1'b0, s1 = 1'b0, rdy = 1'b0;
  logic [15:0] d0 = '0, d1 = '0;
  logic        ack0_a, ack1_a, send_a, ack0_b, ack1_b, send_b;
  logic [15:0] data_a, count_a, data_b, count_b;
  logic [1:0]  grant_a, grant_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  mst_t ma = '{0, 1'b1, 0, 0};
  mst_t mb = '{0, 1'b1, 0, 0};
  exp_t sbq[$];
  vec_t tab[8];

  always #5 clk = ~clk;

  pyramid_merge_arbiter #(.BURST_LEN(BL_A), .TIMEOUT(TO_A)) u_dut_a (
    .CLK(clk), .RESET(reset),
    .In0_SEND(s0), .In0_DATA(d0), .In0_COUNT(16'h0007), .In0_ACK(ack0_a),
    .In1_SEND(s1), .In1_DATA(d1), .In1_COUNT(16'h0009), .In1_ACK(ack1_a),
    .Out1_RDY(rdy), .Out1_ACK(1'b0), .Out1_SEND(send_a), .Out1_DATA(data_a),
    .Out1_COUNT(count_a), .GRANT(grant_a)
  );

  pyramid_merge_arbiter #(.BURST_LEN(BL_B), .TIMEOUT(TO_B)) u_dut_b (
    .CLK(clk), .RESET(reset),
    .In0_SEND(s0), .In0_DATA(d0), .In0_COUNT(16'h0007), .In0_ACK(ack0_b),
    .In1_SEND(s1), .In1_DATA(d1), .In1_COUNT(16'h0009), .In1_ACK(ack1_b),
    .Out1_RDY(rdy), .Out1_ACK(1'b0), .Out1_SEND(send_b), .Out1_DATA(data_b),
    .Out1_COUNT(count_b), .GRANT(grant_b)
  );

  function automatic out_t mk(logic [1:0] g, logic a0, logic a1, logic sd, logic [15:0] d);
    out_t o;
    o.grant = g;
    o.ack0  = a0;
    o.ack1  = a1;
    o.send  = sd;
    o.data  = d;
    o.count = sd ? 16'h0001 : 16'h0000;
    return o;
  endfunction

  function automatic out_t mout(mst_t m, bit rst, logic a0, logic a1, logic r,
                                logic [15:0] x0, logic [15:0] x1);
    out_t o;
    o = '0;
    if (!rst) begin
      o.grant = (m.st == 1) ? 2'b01 : (m.st == 2) ? 2'b10 : 2'b00;
      if (m.st == 1 && a0 && r)      o = mk(2'b01, 1'b1, 1'b0, 1'b1, x0);
      else if (m.st == 2 && a1 && r) o = mk(2'b10, 1'b0, 1'b1, 1'b1, x1);
    end
    return o;
  endfunction

  function automatic mst_t mnext(mst_t m, bit rst, logic a0, logic a1, logic r, int bl, int to);
    mst_t n;
    bit req;
    n = m;
    if (rst) begin
      n.st = 0; n.last = 1'b1; n.bcnt = 0; n.icnt = 0;
      return n;
    end
    if (m.st == 0) begin
      n.bcnt = 0;
      n.icnt = 0;
      if (a0 && a1) n.st = m.last ? 1 : 2;
      else if (a0)  n.st = 1;
      else if (a1)  n.st = 2;
    end else begin
      req = (m.st == 1) ? a0 : a1;
      if (req) begin
        n.icnt = 0;
        if (r) begin
          if (m.bcnt == bl - 1) begin
            n.st = 0; n.last = (m.st == 2);
          end else n.bcnt = m.bcnt + 1;
        end
      end else if (to > 0 && m.icnt == to - 1) begin
        n.st = 0; n.last = (m.st == 2);
      end else if (m.icnt < 65535) n.icnt = m.icnt + 1;
    end
    return n;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got g=%b a0=%b a1=%b s=%b d=%h c=%h exp g=%b a0=%b a1=%b s=%b d=%h c=%h",
               name, cyc, act.grant, act.ack0, act.ack1, act.send, act.data, act.count,
               exp.grant, exp.ack0, exp.ack1, exp.send, exp.data, exp.count);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  // Called at posedge+1: drive, queue expectation, compare at negedge, advance models.
  task automatic cycle(input bit rst, input logic a0, input logic a1, input logic r,
                       input logic [15:0] x0, input logic [15:0] x1,
                       input bit has_tab, input out_t tv);
    exp_t e;
    exp_t got;
    reset = rst; s0 = a0; s1 = a1; rdy = r; d0 = x0; d1 = x1;
    if (rst) begin
      ma = mnext(ma, 1'b1, a0, a1, r, BL_A, TO_A);
      mb = mnext(mb, 1'b1, a0, a1, r, BL_B, TO_B);
    end
    e.a = mout(ma, rst, a0, a1, r, x0, x1);
    e.b = mout(mb, rst, a0, a1, r, x0, x1);
    e.has_tab = has_tab;
    e.tab = tv;
    sbq.push_back(e);
    ma = mnext(ma, rst, a0, a1, r, BL_A, TO_A);
    mb = mnext(mb, rst, a0, a1, r, BL_B, TO_B);
    @(negedge clk);
    got = sbq.pop_front();
    check("dut_a", {grant_a, ack0_a, ack1_a, send_a, data_a, count_a}, got.a);
    check("dut_b", {grant_b, ack0_b, ack1_b, send_b, data_b, count_b}, got.b);
    if (got.has_tab) check("vector", {grant_a, ack0_a, ack1_a, send_a, data_a, count_a}, got.tab);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input bit rst, input logic a0, input logic a1, input logic r,
                    input logic [15:0] x0, input logic [15:0] x1);
    cycle(rst, a0, a1, r, x0, x1, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    int idle_own0;
    int mode;
    logic a0, a1, r;

    // Only port 1 requesting after reset (dut_a, burst 4).
    tab[0] = '{1'b0, 1'b1, 1'b1, 16'h0A00, 16'h0B00, mk(2'b00, 1'b0, 1'b0, 1'b0, 16'h0000)};
    tab[1] = '{1'b0, 1'b1, 1'b1, 16'h0A01, 16'h0B01, mk(2'b10, 1'b0, 1'b1, 1'b1, 16'h0B01)};
    tab[2] = '{1'b0, 1'b1, 1'b0, 16'h0A02, 16'h0B02, mk(2'b10, 1'b0, 1'b0, 1'b0, 16'h0000)};
    tab[3] = '{1'b0, 1'b1, 1'b1, 16'h0A03, 16'h0B02, mk(2'b10, 1'b0, 1'b1, 1'b1, 16'h0B02)};
    tab[4] = '{1'b0, 1'b1, 1'b1, 16'h0A04, 16'h0B03, mk(2'b10, 1'b0, 1'b1, 1'b1, 16'h0B03)};
    tab[5] = '{1'b0, 1'b1, 1'b1, 16'h0A05, 16'h0B04, mk(2'b10, 1'b0, 1'b1, 1'b1, 16'h0B04)};
    tab[6] = '{1'b0, 1'b1, 1'b1, 16'h0A06, 16'h0B05, mk(2'b00, 1'b0, 1'b0, 1'b0, 16'h0000)};
    tab[7] = '{1'b1, 1'b1, 1'b1, 16'h0A07, 16'h0B05, mk(2'b10, 1'b0, 1'b1, 1'b1, 16'h0B05)};

    @(posedge clk);
    #1;
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222, 1'b1, mk(2'b00, 1'b0, 1'b0, 1'b0, 16'h0000));
    go(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    foreach (tab[i])
      cycle(1'b0, tab[i].s0, tab[i].s1, tab[i].rdy, tab[i].d0, tab[i].d1, 1'b1, tab[i].exp);

    // Both producers streaming: alternating bursts with one idle cycle between.
    go(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 20; i++)
      go(1'b0, 1'b1, 1'b1, 1'b1, 16'h0A00 + 16'(i), 16'h0B00 + 16'(i));

    // Port 0 alone with RDY toggling.
    go(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 16; i++)
      go(1'b0, 1'b1, 1'b0, (i % 2) == 0, 16'h0C00 + 16'(i), 16'h0);

    // Port 0 stalls mid-burst while port 1 waits.
    go(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) go(1'b0, 1'b1, 1'b1, 1'b1, 16'h0D00 + 16'(i), 16'h0E00);
    idle_own0 = 0;
    for (int i = 0; i < 24; i++) begin
      if (grant_a == 2'b01) idle_own0++;
      go(1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0E00 + 16'(i));
    end
    check_int("timeout_idle_cycles", idle_own0, 16);
    check_int("grant_after_timeout", int'(grant_a), 2);

    // Reset in the middle of a port-1 burst.
    go(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) go(1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0F00 + 16'(i));
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0F03, 1'b1, mk(2'b00, 1'b0, 1'b0, 1'b0, 16'h0000));
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0A50, 16'h0B50, 1'b1, mk(2'b00, 1'b0, 1'b0, 1'b0, 16'h0000));
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0A51, 16'h0B51, 1'b1, mk(2'b01, 1'b1, 1'b0, 1'b1, 16'h0A51));

    // Random traffic in dense, sparse and mixed phases with occasional resets.
    for (int i = 0; i < 360; i++) begin
      mode = (i / 40) % 3;
      if (mode == 0) begin
        a0 = ($urandom_range(0, 7) != 0); a1 = ($urandom_range(0, 7) != 0);
      end else if (mode == 1) begin
        a0 = ($urandom_range(0, 7) == 0); a1 = ($urandom_range(0, 1) == 0);
      end else begin
        a0 = ($urandom_range(0, 1) == 0); a1 = ($urandom_range(0, 1) == 0);
      end
      r = ($urandom_range(0, 3) != 0);
      go($urandom_range(0, 79) == 0, a0, a1, r, 16'($urandom), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
